// File: rtl/sys_throttle_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : sys_throttle_dispatch
// Purpose  : Qualifies the combined FM_SYS_THROTTLE_N request into minimum-width
//            PROCHOT/MEMHOT assertions per CPU and keeps BMC-visible status.
//            MEMHOT drive is built only with THROTTLE_MEMHOT_DRIVE_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module sys_throttle_dispatch #(
  parameter int FILTER_CYCLES     = 4,
  parameter int MIN_ASSERT_CYCLES = 2000,
  parameter int CNT_W             = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFmSysThrottle_n,
  input  logic             iThrottleEn,
  input  logic             iCpu0PwrGd,
  input  logic             iCpu1PwrGd,
  input  logic             iStatusClr,
  output logic             oFmProchotCpu0_n,
  output logic             oFmProchotCpu1_n,
  output logic             oFmMemhotCpu0_n,
  output logic             oFmMemhotCpu1_n,
  output logic             oThrottleActive,
  output logic             oThrottleSticky,
  output logic [CNT_W-1:0] oThrottleEvtCnt
);

  localparam int cFiltW = $clog2(FILTER_CYCLES + 1);
  localparam int cMinW  = (MIN_ASSERT_CYCLES > 1) ? $clog2(MIN_ASSERT_CYCLES) : 1;

  localparam logic [cFiltW-1:0] cFiltOne  = cFiltW'(1);
  localparam logic [cFiltW-1:0] cFiltLast = cFiltW'(FILTER_CYCLES - 1);
  localparam logic [cMinW-1:0]  cMinLast  = cMinW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  cCntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } throttleState_t;

  logic              rSyncMeta;
  logic              rSync;
  throttleState_t    rState;
  throttleState_t    wStateNext;
  logic [cFiltW-1:0] rFiltCnt;
  logic [cFiltW-1:0] wFiltCntNext;
  logic [cMinW-1:0]  rMinCnt;
  logic [cMinW-1:0]  wMinCntNext;
  logic              wEvent;
  logic              wAsserting;
  logic [CNT_W-1:0]  rEvtCnt;
  logic              rSticky;
  logic              rProchot0_n;
  logic              rProchot1_n;
  logic              rActive;

  // Two-flop synchronizer; idles high so reset never looks like a request.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rSyncMeta <= 1'b1;
      rSync     <= 1'b1;
    end else begin
      rSyncMeta <= iFmSysThrottle_n;
      rSync     <= rSyncMeta;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState   <= ST_IDLE;
      rFiltCnt <= '0;
      rMinCnt  <= '0;
    end else begin
      rState   <= wStateNext;
      rFiltCnt <= wFiltCntNext;
      rMinCnt  <= wMinCntNext;
    end
  end

  // One filter counter serves both QUALIFY (low run) and RELEASE (high run).
  always_comb begin
    wStateNext   = rState;
    wFiltCntNext = rFiltCnt;
    wMinCntNext  = rMinCnt;
    wEvent       = 1'b0;
    if (!iThrottleEn) begin
      wStateNext = ST_IDLE;
    end else begin
      case (rState)
        ST_IDLE: begin
          if (!rSync) begin
            if (FILTER_CYCLES == 1) begin
              wStateNext  = ST_ASSERT;
              wMinCntNext = '0;
              wEvent      = 1'b1;
            end else begin
              wStateNext   = ST_QUALIFY;
              wFiltCntNext = cFiltOne;
            end
          end
        end
        ST_QUALIFY: begin
          if (rSync) begin
            wStateNext = ST_IDLE;
          end else if (rFiltCnt == cFiltLast) begin
            wStateNext  = ST_ASSERT;
            wMinCntNext = '0;
            wEvent      = 1'b1;
          end else begin
            wFiltCntNext = rFiltCnt + 1'b1;
          end
        end
        ST_ASSERT: begin
          // Min counter parks at its terminal value so it can never wrap.
          if (rMinCnt != cMinLast) begin
            wMinCntNext = rMinCnt + 1'b1;
          end
          if ((rMinCnt == cMinLast) && rSync) begin
            if (FILTER_CYCLES == 1) begin
              wStateNext = ST_IDLE;
            end else begin
              wStateNext   = ST_RELEASE;
              wFiltCntNext = cFiltOne;
            end
          end
        end
        ST_RELEASE: begin
          if (!rSync) begin
            wStateNext = ST_ASSERT;
          end else if (rFiltCnt == cFiltLast) begin
            wStateNext = ST_IDLE;
          end else begin
            wFiltCntNext = rFiltCnt + 1'b1;
          end
        end
        default: begin
          wStateNext = ST_IDLE;
        end
      endcase
    end
  end

  // A qualifying event outranks a coincident clear.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rEvtCnt <= '0;
      rSticky <= 1'b0;
    end else if (wEvent) begin
      rSticky <= 1'b1;
      if (iStatusClr) begin
        rEvtCnt <= cCntOne;
      end else if (!(&rEvtCnt)) begin
        rEvtCnt <= rEvtCnt + 1'b1;
      end
    end else if (iStatusClr) begin
      rEvtCnt <= '0;
      rSticky <= 1'b0;
    end
  end

  assign wAsserting = (rState == ST_ASSERT) || (rState == ST_RELEASE);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rProchot0_n <= 1'b1;
      rProchot1_n <= 1'b1;
      rActive     <= 1'b0;
    end else begin
      rProchot0_n <= ~(wAsserting & iCpu0PwrGd);
      rProchot1_n <= ~(wAsserting & iCpu1PwrGd);
      rActive     <= wAsserting;
    end
  end

  assign oFmProchotCpu0_n = rProchot0_n;
  assign oFmProchotCpu1_n = rProchot1_n;
  assign oThrottleActive  = rActive;
  assign oThrottleSticky  = rSticky;
  assign oThrottleEvtCnt  = rEvtCnt;

`ifdef THROTTLE_MEMHOT_DRIVE_EN
  assign oFmMemhotCpu0_n = rProchot0_n;
  assign oFmMemhotCpu1_n = rProchot1_n;
`else
  assign oFmMemhotCpu0_n = 1'b1;
  assign oFmMemhotCpu1_n = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_throttle_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_throttle_dispatch
// Purpose  : Bench for sys_throttle_dispatch; run-length reference model,
//            directed scenarios and randomized segments.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_throttle_dispatch;

  localparam int FILT = 4;
  localparam int MINC = 2000;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef THROTTLE_MEMHOT_DRIVE_EN
  localparam bit MEMHOT_ON = 1'b1;
`else
  localparam bit MEMHOT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, fmIn, en, pg0, pg1, clr;
  logic          p0, p1, m0, m1, act, sticky;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sys_throttle_dispatch #(
    .FILTER_CYCLES    (FILT),
    .MIN_ASSERT_CYCLES(MINC),
    .CNT_W            (CW)
  ) dut (
    .iClk             (clk),
    .iRst             (rst),
    .iFmSysThrottle_n (fmIn),
    .iThrottleEn      (en),
    .iCpu0PwrGd       (pg0),
    .iCpu1PwrGd       (pg1),
    .iStatusClr       (clr),
    .oFmProchotCpu0_n (p0),
    .oFmProchotCpu1_n (p1),
    .oFmMemhotCpu0_n  (m0),
    .oFmMemhotCpu1_n  (m1),
    .oThrottleActive  (act),
    .oThrottleSticky  (sticky),
    .oThrottleEvtCnt  (cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a request qualifies after FILT consecutive enabled low
  // synced cycles; release needs MINC cycles since the event plus FILT
  // consecutive high synced cycles. Outputs are one edge behind.
  bit mValid = 1'b0;
  bit mS0, mS1, mAct, mSticky, mSv, mEvt;
  int mLow, mHigh, mSince, mCnt;
  bit eP0, eP1, eAct;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mS0 = 1'b1; mS1 = 1'b1; mAct = 1'b0;
        mLow = 0; mHigh = 0; mSince = 0; mCnt = 0; mSticky = 1'b0;
        eP0 = 1'b1; eP1 = 1'b1; eAct = 1'b0;
        mValid = 1'b1;
      end else if (mValid) begin
        mSv  = mS1;
        mEvt = 1'b0;
        eP0  = !(mAct && pg0);
        eP1  = !(mAct && pg1);
        eAct = mAct;
        if (!en) begin
          mAct = 1'b0; mLow = 0; mHigh = 0;
        end else if (!mAct) begin
          mLow = mSv ? 0 : mLow + 1;
          if (mLow >= FILT) begin
            mEvt = 1'b1; mAct = 1'b1; mLow = 0; mHigh = 0; mSince = 0;
          end
        end else begin
          if (mSince < MINC) mSince++;
          mHigh = (mSv && mSince >= MINC) ? mHigh + 1 : 0;
          if (mHigh >= FILT) begin
            mAct = 1'b0; mHigh = 0;
          end
        end
        if (mEvt) begin
          mCnt    = clr ? 1 : ((mCnt < CMAX) ? mCnt + 1 : CMAX);
          mSticky = 1'b1;
        end else if (clr) begin
          mCnt    = 0;
          mSticky = 1'b0;
        end
        mS1 = mS0;
        mS0 = fmIn;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mValid) begin
        chk("prochot0", p0, eP0);
        chk("prochot1", p1, eP1);
        chk("memhot0", m0, MEMHOT_ON ? eP0 : 1'b1);
        chk("memhot1", m1, MEMHOT_ON ? eP1 : 1'b1);
        chk("active", act, eAct);
        chk("sticky", sticky, mSticky);
        chk("evtcnt", cnt, mCnt);
      end
    end
  end

  task automatic waitP0(input logic lvl, input int maxCyc, input string name);
    int n;
    n = 0;
    while (p0 !== lvl && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, p0, lvl);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  int stayed;
  int len;

  initial begin
    rst = 1'b1; fmIn = 1'b0; en = 1'b1; pg0 = 1'b1; pg1 = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p0", p0, 1);
    chk("rst_p1", p1, 1);
    chk("rst_m0", m0, 1);
    chk("rst_m1", m1, 1);
    chk("rst_active", act, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_cnt", cnt, 0);

    // Input already low when reset drops: outputs fall at edge 7.
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("lat_edge6_p0", p0, 1);
    @(negedge clk);
    chk("lat_edge7_p0", p0, 0);
    chk("lat_cnt", cnt, 1);
    chk("lat_sticky", sticky, 1);
    chk("model_cnt_pin", mCnt, 1);

    // Input rises right away: minimum width governs, high at edge 6+2000+4.
    fmIn = 1'b1;
    repeat (2002) @(negedge clk);
    chk("minw_edge2009_p0", p0, 0);
    @(negedge clk);
    chk("minw_edge2010_p0", p0, 1);

    // Three-cycle glitch is rejected.
    fmIn = 1'b0;
    repeat (3) @(negedge clk);
    fmIn = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_p0", p0, 1);
    chk("glitch_cnt", cnt, 1);

    // Re-entry from RELEASE keeps outputs asserted, no new event.
    fmIn = 1'b0;
    waitP0(1'b0, 20, "reentry_assert");
    chk("reentry_cnt", cnt, 2);
    repeat (MINC + 5) @(negedge clk);
    stayed = 1;
    fmIn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (p0 !== 1'b0) stayed = 0;
    end
    fmIn = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (p0 !== 1'b0) stayed = 0;
    end
    chk("reentry_never_deassert", stayed, 1);
    chk("reentry_cnt_hold", cnt, 2);
    fmIn = 1'b1;
    waitP0(1'b1, 20, "reentry_release");

    // CPU1 unpowered: its outputs stay high while CPU0 asserts.
    pg1 = 1'b0;
    fmIn = 1'b0;
    waitP0(1'b0, 20, "pg_assert");
    chk("pg_p1_gated", p1, 1);
    chk("pg_m1_gated", m1, 1);
    chk("pg_m0", m0, MEMHOT_ON ? 0 : 1);
    chk("pg_cnt", cnt, 3);
    fmIn = 1'b1;
    waitP0(1'b1, MINC + 20, "pg_release");
    pg1 = 1'b1;

    // Events four and five saturate the 2-bit counter.
    for (int k = 0; k < 2; k++) begin
      fmIn = 1'b0;
      waitP0(1'b0, 20, "sat_assert");
      chk("sat_cnt", cnt, 3);
      fmIn = 1'b1;
      waitP0(1'b1, MINC + 20, "sat_release");
    end

    // Clear alone, then clear coinciding with an event.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", cnt, 0);
    chk("clr_sticky", sticky, 0);
    fmIn = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_evt_cnt", cnt, 1);
    chk("clr_evt_sticky", sticky, 1);
    waitP0(1'b0, 20, "clr_evt_assert");

    // Enable drop mid-ASSERT: outputs high two edges later, status held.
    repeat (10) @(negedge clk);
    en = 1'b0;
    fmIn = 1'b1;
    @(negedge clk);
    chk("en_edge1_p0", p0, 0);
    @(negedge clk);
    chk("en_edge2_p0", p0, 1);
    chk("en_active", act, 0);
    chk("en_cnt", cnt, 1);
    chk("en_sticky", sticky, 1);
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized segments; the compare process checks every cycle.
    for (int seg = 0; seg < 60; seg++) begin
      fmIn = ~fmIn;
      if ($urandom_range(0, 5) == 0) len = int'($urandom_range(MINC, MINC + 40));
      else                           len = int'($urandom_range(1, 2 * FILT + 2));
      en  = ($urandom_range(0, 19) != 0);
      pg0 = ($urandom_range(0, 9) != 0);
      pg1 = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < len; c++) begin
        clr = ($urandom_range(0, 31) == 0);
        @(negedge clk);
      end
      clr = 1'b0;
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_throttle_dispatch.md
# sys_throttle_dispatch

Consumes the combined system-throttle request produced by the smart-logic stage (FM_SYS_THROTTLE_N) and turns it into qualified, minimum-width PROCHOT and MEMHOT assertions for CPU0 and CPU1. Sits directly downstream of the smart-logic block inside the misc-logic area of the core CPLD. It also keeps BMC-visible status: a live active flag, a sticky flag and a saturating event counter.

## Interface
Parameters:
- FILTER_CYCLES, 4: consecutive cycles the synced input must hold a level to qualify assert or release. Must be at least 1.
- MIN_ASSERT_CYCLES, 2000: minimum cycles the outputs stay asserted once qualified. Must be at least 1.
- CNT_W, 8: event counter width.

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset, synchronous, active-high; the block uses one clock and this single reset
- iFmSysThrottle_n  in  1  combined throttle request from the smart-logic stage; low means throttle; asynchronous to iClk
- iThrottleEn  in  1  global enable; low forces the block idle
- iCpu0PwrGd  in  1  CPU0 power good; gates CPU0 outputs
- iCpu1PwrGd  in  1  CPU1 power good; gates CPU1 outputs
- iStatusClr  in  1  one-cycle pulse; clears the sticky flag and the event counter
- oFmProchotCpu0_n  out  1  PROCHOT to CPU0, active-low
- oFmProchotCpu1_n  out  1  PROCHOT to CPU1, active-low
- oFmMemhotCpu0_n  out  1  MEMHOT to CPU0 DIMMs, active-low
- oFmMemhotCpu1_n  out  1  MEMHOT to CPU1 DIMMs, active-low
- oThrottleActive  out  1  high while the state is ASSERT or RELEASE, registered
- oThrottleSticky  out  1  set on every qualified event
- oThrottleEvtCnt  out  CNT_W  qualified-event count; saturates at all-ones

## Operation
- **Input synchronizer:** 2-flop synchronizer on iFmSysThrottle_n. Both flops reset to 1. The synced value is called s.
- **IDLE:** outputs are deasserted.
  - If s=0 and iThrottleEn=1: load filter count with 1 and go to QUALIFY.
  - If FILTER_CYCLES=1: go directly to ASSERT instead.
- **QUALIFY:** increment the filter count on each cycle with s=0.
  - Any cycle with s=1 returns to IDLE. No event is counted.
  - When the count reaches FILTER_CYCLES: go to ASSERT, clear the min counter, increment the event counter (saturating) and set sticky.
- **ASSERT:** outputs are asserted and the min counter increments every cycle.
  - Once min counter ≥ MIN_ASSERT_CYCLES−1 and s=1: load release count with 1 and go to RELEASE.
  - If FILTER_CYCLES=1: go directly to IDLE instead.
- **RELEASE:** outputs stay asserted.
  - Count consecutive s=1 cycles. Reaching FILTER_CYCLES goes to IDLE.
  - Any s=0 returns to ASSERT. The min counter is not cleared and no new event is counted.
- **iThrottleEn=0:** state goes to IDLE on the next edge from any state. Counters hold. Status is unchanged.
- **Power-good gating:** if iCpuKPwrGd=0, both CPU-K outputs are driven 1 regardless of state, so an unpowered CPU is never back-driven. oThrottleActive is not gated.
- **Status clear vs event:**
  - iStatusClr alone: counter goes to 0 and sticky to 0 on the next edge.
  - iStatusClr in the same cycle as a qualifying event: the event wins, giving counter=1 and sticky=1.
- **Counter arithmetic:** unsigned, CNT_W bits. At all-ones it holds and never wraps.
- **Internal counter widths:** sized by $clog2 of the parameters. The min counter saturates and never wraps.

## Timing
- **Reset values:** all _n outputs 1, oThrottleActive 0, oThrottleSticky 0, oThrottleEvtCnt 0, state IDLE. Reset takes priority over all inputs.
- **Assert latency:** input falls between edges 0 and 1; outputs are low after edge FILTER_CYCLES+3. The default is edge 7.
- **Release latency:** after the minimum is met, outputs are high FILTER_CYCLES+3 edges after the input rises.
- **Minimum width:** outputs stay low for at least MIN_ASSERT_CYCLES consecutive cycles per qualified event.
- **Registered outputs:** all outputs, including status, are registered and update one edge after the state or status change. Power-good gating is part of that output register, so gating also has 1-cycle latency.
- **Glitch rejection:** a low pulse shorter than FILTER_CYCLES synced cycles produces no output change and no count.

## Configuration
- **THROTTLE_MEMHOT_DRIVE_EN defined:** MEMHOT outputs follow the same state and power-good gating as the PROCHOT outputs.
- **THROTTLE_MEMHOT_DRIVE_EN undefined:** oFmMemhotCpu0_n and oFmMemhotCpu1_n are constant 1, including during reset. PROCHOT outputs and status are unchanged.

## Test plan
- **Reset:** hold iRst 3 cycles with input low → all _n outputs 1, counter 0, sticky 0. Release with input held low → PROCHOT low at edge 7 after reset deasserts, counter = 1.
- **Glitch rejection:** 3-cycle low pulse with FILTER_CYCLES=4 → no output change, counter stays 0. 4-cycle synced low → outputs low held for 2000 cycles, counter = 1.
- **Re-entry during RELEASE:** assert, then raise the input, then lower it again 2 cycles later in RELEASE → outputs never deassert, counter unchanged at 1.
- **Power-good and macro:** iCpu1PwrGd=0 during an event → CPU1 PROCHOT/MEMHOT stay 1 while CPU0 outputs go 0. With the macro undefined, both MEMHOT outputs are 1 throughout.
- **Saturation and clear:** CNT_W=2, 5 qualified events → counter = 3. iStatusClr coinciding with an event → counter = 1, sticky = 1.
- **Enable drop:** drop iThrottleEn mid-ASSERT → outputs high 2 edges later, sticky and counter unchanged.
